// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: receive-side single-frame buffer fed by the UART RX byte stream.
// Bytes are written at an auto-incrementing address. When a frame is complete it is
// held for random-access reads until the consumer acknowledges it. A partial frame
// that stalls for TIMEOUT_CYCLES idle cycles is discarded.
// Optional feature: define RX_SOF_SYNC_EN to wait for a SOF_BYTE marker before each
// frame. The marker byte itself is not stored.
module rx_frame_buffer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TOTAL_PIXELS   = 42240,
    parameter int unsigned ADDR_WIDTH     = $clog2(TOTAL_PIXELS),
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [DATA_WIDTH-1:0] SOF_BYTE = 8'hAA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rAddr,
    output logic [DATA_WIDTH-1:0] rData,
    input  logic                  frame_ack,
    output logic                  frame_ready,
    output logic [ADDR_WIDTH-1:0] fill_level,
    output logic                  overrun,
    output logic                  timeout_err
);

    localparam int unsigned IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LAST_ADDR = TOTAL_PIXELS - 1;
    localparam int unsigned IDLE_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } state_t;

`ifdef RX_SOF_SYNC_EN
    localparam state_t ST_RESTART = ST_SYNC;
`else
    localparam state_t ST_RESTART = ST_FILL;
    logic unused_sof;
    assign unused_sof = ^SOF_BYTE;
`endif

    state_t              state, state_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_n;
    logic [ADDR_WIDTH-1:0] fill_n;
    logic                ready_n;
    logic                overrun_n;
    logic                tout_n;
    logic                wr_en;

    logic [DATA_WIDTH-1:0] mem [TOTAL_PIXELS];

    // State and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RESTART;
            idle_cnt    <= '0;
            fill_level  <= '0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            idle_cnt    <= idle_n;
            fill_level  <= fill_n;
            frame_ready <= ready_n;
            overrun     <= overrun_n;
            timeout_err <= tout_n;
        end
    end

    // Next-state logic: capture, idle timeout, hold-until-ack.
    always_comb begin
        state_n   = state;
        idle_n    = idle_cnt;
        fill_n    = fill_level;
        ready_n   = frame_ready;
        overrun_n = overrun;
        tout_n    = 1'b0;
        wr_en     = 1'b0;
        case (state)
`ifdef RX_SOF_SYNC_EN
            ST_SYNC: begin
                idle_n = '0;
                if (rx_valid && (rx_data == SOF_BYTE)) begin
                    state_n = ST_FILL;
                end
            end
`endif
            ST_FILL: begin
                if (rx_valid) begin
                    // A byte in the expiry cycle still counts, so it is handled first.
                    wr_en  = 1'b1;
                    idle_n = '0;
                    if (fill_level == ADDR_WIDTH'(LAST_ADDR)) begin
                        fill_n  = '0;
                        ready_n = 1'b1;
                        state_n = ST_READY;
                    end else begin
                        fill_n = fill_level + 1'b1;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (fill_level != '0)) begin
                    if (idle_cnt == IDLE_W'(IDLE_LAST)) begin
                        fill_n  = '0;
                        idle_n  = '0;
                        tout_n  = 1'b1;
                        state_n = ST_RESTART;
                    end else begin
                        idle_n = idle_cnt + 1'b1;
                    end
                end
            end
            ST_READY: begin
                // The ack takes priority over a byte arriving in the same cycle.
                if (frame_ack) begin
                    ready_n   = 1'b0;
                    overrun_n = 1'b0;
                    state_n   = ST_RESTART;
                end else if (rx_valid) begin
                    overrun_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_RESTART;
            end
        endcase
    end

    // Frame memory. The read port returns old data on a same-address write.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[fill_level] <= rx_data;
        end
        if (re) begin
            rData <= mem[rAddr];
        end
    end

endmodule
